// File: rtl/programmable_blinker.sv
// Square-wave blinker whose half-period is BASE_TICKS << speed_idx timebase ticks.
// Rising edges on shift_left and shift_right step the speed index up or down, saturating at the ends.
module programmable_blinker #(
  parameter int BASE_TICKS = 4,
  parameter int MAX_IDX    = 7,
  parameter int RESET_IDX  = 3,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       shift_left,
  input  logic       shift_right,
  output logic       blink,
  output logic [2:0] speed_idx,
  output logic       at_min,
  output logic       at_max
);

  localparam logic [2:0]     MAX_IDX_L   = 3'(MAX_IDX);
  localparam logic [2:0]     RESET_IDX_L = 3'(RESET_IDX);
  localparam logic [CNT_W:0] BASE_L      = (CNT_W + 1)'(BASE_TICKS);
  localparam logic [CNT_W:0] ONE_WIDE    = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sl_q, sr_q;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  logic             sl_edge, sr_edge, both_edges;
  logic             step_up, step_dn, idx_chg;
  logic [CNT_W:0]   hp_full, hp_full_m1;
  logic [CNT_W-1:0] hp_m1;

  assign sl_edge    = shift_left  & ~sl_q;
  assign sr_edge    = shift_right & ~sr_q;
  assign both_edges = sl_edge & sr_edge;
  assign step_up    = sl_edge & ~sr_edge;
  assign step_dn    = sr_edge & ~sl_edge;

  // One bit wider than the counter so BASE_TICKS << MAX_IDX == 2^CNT_W is representable.
  assign hp_full    = BASE_L << idx_q;
  assign hp_full_m1 = hp_full - ONE_WIDE;
  assign hp_m1      = hp_full_m1[CNT_W-1:0];

  always_comb begin
    idx_d = idx_q;
    if (step_up && (idx_q != MAX_IDX_L)) begin
      idx_d = idx_q + 3'd1;
    end else if (step_dn && (idx_q != 3'd0)) begin
      idx_d = idx_q - 3'd1;
    end
  end

  assign idx_chg = (idx_d != idx_q);

  // Priority: disable wins, then a speed change restarts the half-period,
  // then a collided shift freezes the phase, otherwise ticks are counted.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (!enable) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (idx_chg) begin
      cnt_d = '0;
    end else if (tick && !both_edges) begin
      if (cnt_q == hp_m1) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      idx_q   <= RESET_IDX_L;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      sl_q    <= shift_left;
      sr_q    <= shift_right;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink     = blink_q;
  assign speed_idx = idx_q;
  assign at_min    = (idx_q == 3'd0);
  assign at_max    = (idx_q == MAX_IDX_L);

endmodule

// File: tb/tb_programmable_blinker.sv
// Bench for programmable_blinker: directed scenarios plus random traffic, checked
// every cycle against a tick-counting reference model of the blinker.
module tb_programmable_blinker;

  localparam int BASE = 4;
  localparam int MAXI = 7;
  localparam int RSTI = 3;
  localparam int CW   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       shift_left = 1'b0;
  logic       shift_right = 1'b0;
  logic       blink;
  logic [2:0] speed_idx;
  logic       at_min;
  logic       at_max;

  int checks = 0;
  int failures = 0;

  programmable_blinker #(
    .BASE_TICKS(BASE),
    .MAX_IDX   (MAXI),
    .RESET_IDX (RSTI),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .enable     (enable),
    .shift_left (shift_left),
    .shift_right(shift_right),
    .blink      (blink),
    .speed_idx  (speed_idx),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  always #5 clk = ~clk;

  // Reference model: counts ticks seen in the current half-period and flips
  // the output once that count reaches BASE * 2^idx.
  int   m_idx = RSTI;
  int   m_seen = 0;
  logic m_blink = 1'b0;
  logic m_psl = 1'b0;
  logic m_psr = 1'b0;
  logic m_sle, m_sre;
  int   m_nidx;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_idx   = RSTI;
      m_seen  = 0;
      m_blink = 1'b0;
      m_psl   = 1'b0;
      m_psr   = 1'b0;
    end else begin
      m_sle  = shift_left && !m_psl;
      m_sre  = shift_right && !m_psr;
      m_psl  = shift_left;
      m_psr  = shift_right;
      m_nidx = m_idx;
      if (m_sle && !m_sre) m_nidx = (m_idx < MAXI) ? m_idx + 1 : MAXI;
      if (m_sre && !m_sle) m_nidx = (m_idx > 0) ? m_idx - 1 : 0;
      if (!enable) begin
        m_seen  = 0;
        m_blink = 1'b0;
      end else if (m_nidx != m_idx) begin
        m_seen = 0;
      end else if (m_sle && m_sre) begin
        m_seen = m_seen;
      end else if (tick) begin
        m_seen = m_seen + 1;
        if (m_seen == BASE * (1 << m_idx)) begin
          m_seen  = 0;
          m_blink = ~m_blink;
        end
      end
      m_idx = m_nidx;
    end
  end

  function automatic logic [5:0] model_vec();
    logic [2:0] idx3;
    idx3 = 3'(m_idx);
    return {m_blink, idx3, m_idx == 0, m_idx == MAXI};
  endfunction

  // Advances until blink changes; n is the number of cycles taken (bound+1 on timeout).
  task automatic wait_toggle(input int bound, output int n);
    logic b;
    b = blink;
    n = 0;
    while (blink === b && n <= bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL rst_blink got=%b exp=0", blink); end
    checks++; if (speed_idx !== 3'(RSTI)) begin failures++; $display("FAIL rst_idx got=%0d exp=%0d", speed_idx, RSTI); end
    checks++; if (at_min !== 1'b0 || at_max !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", at_min, at_max); end
    // A shift input already high when reset releases counts as an edge.
    shift_left = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (speed_idx !== 3'(RSTI + 1)) begin failures++; $display("FAIL rst_edge_idx got=%0d exp=%0d", speed_idx, RSTI + 1); end
    shift_left = 1'b0;
    @(negedge clk);
    shift_right = 1'b1;
    @(negedge clk);
    checks++; if (speed_idx !== 3'(RSTI)) begin failures++; $display("FAIL rst_back_idx got=%0d exp=%0d", speed_idx, RSTI); end
    shift_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_blink();
    int first_rise;
    int toggles;
    logic prev;
    first_rise = 0;
    toggles = 0;
    prev = blink;
    enable = 1'b1;
    tick = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL default_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      if (blink && first_rise == 0) first_rise = i;
      if (blink !== prev) toggles++;
      prev = blink;
    end
    checks++; if (first_rise != 32) begin failures++; $display("FAIL default_first_rise got=%0d exp=32", first_rise); end
    checks++; if (toggles != 3) begin failures++; $display("FAIL default_toggles got=%0d exp=3", toggles); end
  endtask

  task automatic test_shift_hold();
    logic b0;
    int chg;
    b0 = blink;
    chg = 0;
    shift_left = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL hold_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      if (i == 10) shift_left = 1'b0;
      if (blink !== b0 && chg == 0) chg = i;
    end
    checks++; if (speed_idx !== 3'd4) begin failures++; $display("FAIL hold_idx got=%0d exp=4", speed_idx); end
    checks++; if (chg != 65) begin failures++; $display("FAIL hold_next_toggle got=%0d exp=65", chg); end
  endtask

  task automatic test_right_pulses();
    int n;
    for (int p = 0; p < 8; p++) begin
      shift_right = 1'b1;
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL rpulse_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      shift_right = 1'b0;
      @(negedge clk);
    end
    checks++; if (speed_idx !== 3'd0 || at_min !== 1'b1) begin failures++; $display("FAIL rpulse_min got=%0d/%b exp=0/1", speed_idx, at_min); end
    wait_toggle(20, n);
    wait_toggle(20, n);
    checks++; if (n != 4) begin failures++; $display("FAIL rpulse_hp got=%0d exp=4", n); end
  endtask

  task automatic test_simultaneous();
    int n;
    int chg;
    logic b;
    wait_toggle(20, n);
    b = blink;
    chg = 0;
    shift_left = 1'b1;
    shift_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL simul_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      if (blink !== b && chg == 0) chg = i;
    end
    checks++; if (speed_idx !== 3'd0) begin failures++; $display("FAIL simul_idx got=%0d exp=0", speed_idx); end
    checks++; if (chg != 5) begin failures++; $display("FAIL simul_phase got=%0d exp=5", chg); end
    shift_left = 1'b0;
    shift_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_left_pulses();
    int n;
    for (int p = 0; p < 8; p++) begin
      shift_left = 1'b1;
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL lpulse_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      shift_left = 1'b0;
      @(negedge clk);
    end
    checks++; if (speed_idx !== 3'd7 || at_max !== 1'b1 || at_min !== 1'b0) begin failures++; $display("FAIL lpulse_max got=%0d/%b%b exp=7/01", speed_idx, at_min, at_max); end
    wait_toggle(600, n);
    wait_toggle(600, n);
    checks++; if (n != 512) begin failures++; $display("FAIL lpulse_hp got=%0d exp=512", n); end
  endtask

  task automatic test_enable();
    int n;
    int first_rise;
    n = 0;
    while (blink !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (blink !== 1'b1) begin failures++; $display("FAIL en_reach_high got=%b exp=1", blink); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL en_drop got=%b exp=0", blink); end
    for (int p = 0; p < 2; p++) begin
      shift_right = 1'b1;
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL en_shift_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      shift_right = 1'b0;
      @(negedge clk);
    end
    checks++; if (speed_idx !== 3'd5 || blink !== 1'b0) begin failures++; $display("FAIL en_off_shift got=%0d/%b exp=5/0", speed_idx, blink); end
    enable = 1'b1;
    first_rise = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL en_on_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      if (blink && first_rise == 0) first_rise = i;
    end
    checks++; if (first_rise != 128) begin failures++; $display("FAIL en_first_rise got=%0d exp=128", first_rise); end
  endtask

  task automatic test_reset_midcount();
    int n;
    int t1, t2, tcnt;
    logic prev;
    shift_left = 1'b1;
    @(negedge clk);
    shift_left = 1'b0;
    @(negedge clk);
    checks++; if (speed_idx !== 3'd6) begin failures++; $display("FAIL mid_idx6 got=%0d exp=6", speed_idx); end
    n = 0;
    while (blink !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (blink !== 1'b0 || speed_idx !== 3'(RSTI)) begin failures++; $display("FAIL mid_async got=%b/%0d exp=0/%0d", blink, speed_idx, RSTI); end
    @(negedge clk);
    reset_n = 1'b1;
    prev = blink;
    t1 = 0;
    t2 = 0;
    tcnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick = (i % 4 == 0);
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL mid_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
      if (blink !== prev) begin
        tcnt++;
        if (tcnt == 1) t1 = i;
        if (tcnt == 2) t2 = i;
      end
      prev = blink;
    end
    checks++; if (t2 - t1 != 128) begin failures++; $display("FAIL mid_slow_hp got=%0d exp=128", t2 - t1); end
    tick = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom_range(0, 19) != 0);
      tick        = $urandom_range(0, 1) != 0;
      shift_left  = ($urandom_range(0, 15) == 0);
      shift_right = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      checks++; if ({blink, speed_idx, at_min, at_max} !== model_vec()) begin failures++; $display("FAIL rand_cyc t=%0t got=%b exp=%b", $time, {blink, speed_idx, at_min, at_max}, model_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_default_blink();
    test_shift_hold();
    test_right_pulses();
    test_simultaneous();
    test_left_pulses();
    test_enable();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
